// File: rtl/mem_port_bridge.sv
// Request FIFO in front of a single-cycle memory port, with an ordered read-response path.
// Define MEM_PORT_BRIDGE_RSP_REG_EN to register rsp_valid/rsp_data (adds one cycle of response latency).
module mem_port_bridge #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_rd_wr,
   input  logic [ADDR_W-1:0]        req_add,
   input  logic [DATA_W-1:0]        req_data,
   input  logic                     flush,
   input  logic                     mem_hold,
   output logic                     mem_en,
   output logic                     mem_rd_wr,
   output logic [ADDR_W-1:0]        mem_add,
   output logic [DATA_W-1:0]        mem_data,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic                     rsp_valid,
   output logic [DATA_W-1:0]        rsp_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   state_t            state;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              fifo_rd_wr [DEPTH];
   logic [ADDR_W-1:0] fifo_add   [DEPTH];
   logic [DATA_W-1:0] fifo_data  [DEPTH];
   logic              push;
   logic              pop;
   logic              rd_pend;

   assign req_ready = (count != FULL_CNT) && !flush && !reset;
   assign push      = req_valid && req_ready;
   assign pop       = (count != '0) && !mem_hold && !flush && !reset;

   // ISSUE is entered exactly on edges that pop, so it doubles as the access strobe.
   assign mem_en    = (state == ISSUE);

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_rd_wr[wr_ptr] <= req_rd_wr;
         fifo_add[wr_ptr]   <= req_add;
         fifo_data[wr_ptr]  <= req_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_rd_wr <= 1'b0;
         mem_add   <= '0;
         mem_data  <= '0;
         rd_pend   <= 1'b0;
      end else begin
         // An access already on the port completes even across a flush.
         rd_pend <= mem_en && !mem_rd_wr;

         if (pop) begin
            state     <= ISSUE;
            mem_rd_wr <= fifo_rd_wr[rd_ptr];
            mem_add   <= fifo_add[rd_ptr];
            mem_data  <= fifo_data[rd_ptr];
         end else if ((count != '0) && mem_hold && !flush) begin
            state <= HOLD;
         end else begin
            state <= IDLE;
         end

         if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
         end
      end
   end

`ifdef MEM_PORT_BRIDGE_RSP_REG_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= rd_pend;
         rsp_data  <= mem_rdata;
      end
   end
`else
   assign rsp_valid = rd_pend;
   assign rsp_data  = mem_rdata;
`endif

endmodule

// File: tb/tb_mem_port_bridge.sv
// Directed and randomized checks of mem_port_bridge against a queue-based transaction model.
module tb_mem_port_bridge;

   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_rd_wr = 1'b0;
   logic [AW-1:0] req_add = '0;
   logic [DW-1:0] req_data = '0;
   logic          flush = 1'b0;
   logic          mem_hold = 1'b0;
   logic          mem_en;
   logic          mem_rd_wr;
   logic [AW-1:0] mem_add;
   logic [DW-1:0] mem_data;
   logic [DW-1:0] mem_rdata = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic [CW-1:0] count;

   mem_port_bridge #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_rd_wr(req_rd_wr), .req_add(req_add), .req_data(req_data), .flush(flush),
      .mem_hold(mem_hold), .mem_en(mem_en), .mem_rd_wr(mem_rd_wr), .mem_add(mem_add),
      .mem_data(mem_data), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .count(count)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic          rw;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } req_t;

   // Reference model: the queue holds accepted-but-not-issued requests.
   req_t          q[$];
   logic          m_en = 1'b0, m_rw = 1'b0, m_pend = 1'b0;
   logic [AW-1:0] m_add = '0;
   logic [DW-1:0] m_data = '0;
   logic          m_rsp_v = 1'b0;
   logic [DW-1:0] m_rsp_d = '0;
   bit            model_ok = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input logic v, input logic rw, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic fl, input logic hold,
                        input logic rst, input logic [DW-1:0] rd);
      bit   do_push, do_pop, new_pend;
      req_t r;
      req_valid = v; req_rd_wr = rw; req_add = a; req_data = d;
      flush = fl; mem_hold = hold; reset = rst; mem_rdata = rd;
      #1;
      if (model_ok) begin
         chk("req_ready", 64'(req_ready), 64'(!rst && !fl && (q.size() < DEPTH)));
`ifndef MEM_PORT_BRIDGE_RSP_REG_EN
         chk("rsp_valid", 64'(rsp_valid), 64'(m_pend));
         if (m_pend) chk("rsp_data", 64'(rsp_data), 64'(mem_rdata));
`endif
      end
      @(posedge clock);
      if (rst) begin
         q.delete();
         m_en = 1'b0; m_rw = 1'b0; m_add = '0; m_data = '0; m_pend = 1'b0;
         m_rsp_v = 1'b0; m_rsp_d = '0;
         model_ok = 1'b1;
      end else begin
         new_pend = m_en && !m_rw;
         m_rsp_v  = m_pend;
         m_rsp_d  = mem_rdata;
         do_push  = v && !fl && (q.size() < DEPTH);
         do_pop   = (q.size() != 0) && !hold && !fl;
         m_en     = do_pop;
         if (do_pop) begin
            r = q.pop_front();
            m_rw = r.rw; m_add = r.a; m_data = r.d;
         end
         if (fl) q.delete();
         if (do_push) q.push_back('{rw: rw, a: a, d: d});
         m_pend = new_pend;
      end
      #1;
      if (model_ok) begin
         chk("count", 64'(count), 64'(q.size()));
         chk("mem_en", 64'(mem_en), 64'(m_en));
         chk("mem_rd_wr", 64'(mem_rd_wr), 64'(m_rw));
         chk("mem_add", 64'(mem_add), 64'(m_add));
         chk("mem_data", 64'(mem_data), 64'(m_data));
`ifdef MEM_PORT_BRIDGE_RSP_REG_EN
         chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp_v));
         if (m_rsp_v) chk("rsp_data", 64'(rsp_data), 64'(m_rsp_d));
`endif
      end
   endtask

   task automatic idle(input int n, input logic [DW-1:0] rd);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, rd);
   endtask

   initial begin
      // reset
      cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0);
      cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0);
      idle(2, '0);

      // single write
      cycle(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, '0);
      idle(4, 32'h0BAD0BAD);

      // single read, memory returns a fixed word
      cycle(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 32'h12345678);
      idle(5, 32'h12345678);

      // hold with five requests into a four-entry FIFO
      for (int i = 0; i < 5; i++)
         cycle(1'b1, 1'(i % 2), 32'(32'h200 + 4 * i), 32'(32'hA000 + i), 1'b0, 1'b1, 1'b0, '0);
      cycle(1'b1, 1'b0, 32'h210, 32'hA004, 1'b0, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, 32'h210, 32'hA004, 1'b0, 1'b0, 1'b0, '0);
      idle(8, 32'h55AA55AA);

      // continuous push and pop, pointers wrap
      for (int i = 0; i < 10; i++)
         cycle(1'b1, 1'b0, 32'(32'h100 + i), $urandom, 1'b0, 1'b0, 1'b0, $urandom);
      idle(4, 32'hC0FFEE00);

      // flush with three queued and a read in flight
      cycle(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0, '0);
      cycle(1'b1, 1'b1, 32'h50, 32'h1, 1'b0, 1'b1, 1'b0, '0);
      cycle(1'b1, 1'b1, 32'h54, 32'h2, 1'b0, 1'b1, 1'b0, '0);
      cycle(1'b1, 1'b1, 32'h58, 32'h3, 1'b0, 1'b0, 1'b0, '0);
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 32'hFEEDF00D);
      idle(5, 32'hFEEDF00D);

      // reset with two queued and a read pending
      cycle(1'b1, 1'b0, 32'h60, 32'h0, 1'b0, 1'b1, 1'b0, '0);
      cycle(1'b1, 1'b1, 32'h64, 32'h1, 1'b0, 1'b1, 1'b0, '0);
      cycle(1'b1, 1'b1, 32'h68, 32'h2, 1'b0, 1'b0, 1'b0, '0);
      cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 32'h77777777);
      idle(4, 32'h77777777);

      // randomized traffic
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom, $urandom,
               $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 59) == 0, $urandom);
      idle(4, $urandom);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_port_bridge.md
MEM_PORT_BRIDGE -- requirements
Module: mem_port_bridge

Interface
REQ-001 Parameter DATA_W, default 32, meaning data width of request, memory and response data.
REQ-002 Parameter ADDR_W, default 32, meaning address width.
REQ-003 Parameter DEPTH, default 4, meaning request FIFO entries; power of 2, >=2.
REQ-004 clock  input  1  sole clock, all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  bridge accepts request this cycle.
REQ-008 req_rd_wr  input  1  1 = write, 0 = read.
REQ-009 req_add  input  ADDR_W  request address.
REQ-010 req_data  input  DATA_W  write data; ignored for reads.
REQ-011 flush  input  1  discard all queued requests.
REQ-012 mem_hold  input  1  memory busy; no issue this cycle.
REQ-013 mem_en  output  1  memory access strobe, one cycle per access.
REQ-014 mem_rd_wr  output  1  1 = write, 0 = read; valid with mem_en.
REQ-015 mem_add  output  ADDR_W  access address.
REQ-016 mem_data  output  DATA_W  write data.
REQ-017 mem_rdata  input  DATA_W  read data, valid the cycle after a read mem_en.
REQ-018 rsp_valid  output  1  read response strobe.
REQ-019 rsp_data  output  DATA_W  read response data.
REQ-020 count  output  $clog2(DEPTH)+1  queued entries.

Function
REQ-021 Accept: req_valid && req_ready at a posedge SHALL push {rd_wr, add, data} into the FIFO.
REQ-022 req_ready SHALL be !full && !flush && !reset; full means count == DEPTH.
REQ-023 Issue: at a posedge with count != 0, !mem_hold and !flush, the head SHALL be popped and loaded into the mem_en, mem_rd_wr, mem_add and mem_data registers. mem_en is 1 the next cycle.
REQ-024 mem_en SHALL be 0 in every cycle that follows a posedge without a pop; mem_add, mem_data and mem_rd_wr SHALL hold their last values.
REQ-025 Latency: a request accepted at edge N into an empty FIFO SHALL produce mem_en high in the cycle after edge N+1.
REQ-026 Order: requests SHALL issue strictly in acceptance order. Writes SHALL produce no response.
REQ-027 Read response: in the cycle after a read mem_en, rsp_valid SHALL be 1 and rsp_data SHALL equal mem_rdata combinationally.
REQ-028 Push and pop at the same edge SHALL leave count unchanged. Both pointers SHALL wrap modulo DEPTH.
REQ-029 Full: no push occurs, and a pop at that edge does not make req_ready high in the same cycle.
REQ-030 Empty: no pop occurs, and mem_en is 0 in the next cycle.
REQ-031 flush SHALL set count = 0 and both pointers = 0 at the edge, with no push or pop at that edge.
REQ-032 An access already on mem_* when flush is asserted SHALL complete, and its read response SHALL still be delivered.
REQ-033 mem_hold SHALL only block pops; pushes continue until full.
REQ-034 Issue state machine states: IDLE (count == 0), ISSUE (pop this edge), HOLD (count != 0 && mem_hold). Transitions are evaluated every edge from count, mem_hold and flush.

Reset
REQ-035 While reset is high at an edge, the bridge SHALL clear count, both pointers, mem_en, rsp_valid and the internal pending-read flag.
REQ-036 The same reset SHALL clear mem_rd_wr, mem_add and mem_data to 0, and set the state machine to IDLE.
REQ-037 Reset mid-operation SHALL drop all queued requests and any pending read response. rsp_valid SHALL be 0 in the cycle after reset.
REQ-038 rsp_data is don't-care while rsp_valid is 0.

Configuration
REQ-039 With macro MEM_PORT_BRIDGE_RSP_REG_EN defined, rsp_valid and rsp_data SHALL be registered; the response appears 2 cycles after a read mem_en, and both reset to 0.
REQ-040 Without MEM_PORT_BRIDGE_RSP_REG_EN, the response path SHALL be combinational as in REQ-027 (1 cycle after mem_en).

Verification
REQ-041 Single write, add=0x10, data=0xDEADBEEF into empty bridge: mem_en high 2 cycles after accept with mem_rd_wr=1, mem_add=0x10 and mem_data=0xDEADBEEF; rsp_valid stays 0.
REQ-042 Read add=0x20, with memory returning 0x12345678: rsp_valid high once with rsp_data=0x12345678, 1 cycle after mem_en (2 cycles with macro defined).
REQ-043 mem_hold=1 while driving 5 requests with DEPTH=4: 4 accepted and count=4. req_ready=0 on the 5th until hold is released; then 5 accesses issue in order, one per cycle.
REQ-044 Continuous push and pop for 10 requests: count stays at 1 and pointers wrap twice; the issued address sequence matches the input sequence.
REQ-045 flush with 3 queued requests and one read in flight: count=0 next cycle, the in-flight read response is delivered, and no further mem_en occurs.
REQ-046 reset asserted with 2 queued requests and a pending read: next cycle count=0, mem_en=0, rsp_valid=0, and no late response appears.
